fetch_ctrl: RTL and testbench

Sequencing controller for the 256 x 9-bit instruction memory. It loads a program into the memory through a write-side handshake, then drives the 8-bit pc into the combinational read port. It steps pc each cycle, honouring stall and branch redirect, detects the halt instruction, and reports completion and a run-cycle count. It sits between the testbench/loader and the core's decode stage.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_ctrl_sat_counter.sv | 32 +++
 rtl/fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and state encoding for the fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 9;
   localparam int CNT_W   = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR  = 9'b101100100;
   localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b111111111;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t c_ST_IDLE = 2'd0;
   localparam fetch_state_t c_ST_LOAD = 2'd1;
   localparam fetch_state_t c_ST_RUN  = 2'd2;
   localparam fetch_state_t c_ST_DONE = 2'd3;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + c_ONE;
      end
   end

   assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Loads the instruction memory, then sequences pc through it
//               with stall/branch handling, halt detection and cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
   parameter int                     PC_W       = fetch_pkg::PC_W,
   parameter int                     INSTR_W    = fetch_pkg::INSTR_W,
   parameter logic [INSTR_W-1:0]     NOP_INSTR  = fetch_pkg::NOP_INSTR,
   parameter logic [INSTR_W-1:0]     HALT_INSTR = fetch_pkg::HALT_INSTR,
   parameter int                     CNT_W      = fetch_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               load_en,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   output logic               load_ready,
   output logic               imem_wr_en,
   output logic [PC_W-1:0]    imem_wr_addr,
   output logic [INSTR_W-1:0] imem_wr_data,
   output logic [PC_W-1:0]    imem_pc,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic               done,
   output logic [CNT_W-1:0]   cycle_count
);

   import fetch_pkg::*;

   localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [PC_W-1:0] c_PC_MAX = {PC_W{1'b1}};

   fetch_state_t    r_state;
   fetch_state_t    w_state_nx;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_nx;
   logic [PC_W-1:0] r_wr_addr;
   logic [PC_W-1:0] w_wr_addr_nx;
   logic            r_done;
   logic            w_done_nx;
   logic            w_cnt_clear;
   logic            w_in_load;
   logic            w_in_run;

   assign w_in_load = (r_state == c_ST_LOAD);
   assign w_in_run  = (r_state == c_ST_RUN);

   always_comb begin
      w_state_nx   = r_state;
      w_pc_nx      = r_pc;
      w_wr_addr_nx = r_wr_addr;
      w_done_nx    = r_done;
      w_cnt_clear  = 1'b0;

      case (r_state)
         c_ST_IDLE, c_ST_DONE: begin
            // load_en wins over start when both arrive together
            if (load_en) begin
               w_state_nx   = c_ST_LOAD;
               w_wr_addr_nx = '0;
               w_done_nx    = 1'b0;
            end else if (start) begin
               w_state_nx  = c_ST_RUN;
               w_pc_nx     = '0;
               w_done_nx   = 1'b0;
               w_cnt_clear = 1'b1;
            end
         end

         c_ST_LOAD: begin
            if (load_valid) begin
               w_wr_addr_nx = r_wr_addr + c_PC_ONE;
               if (r_wr_addr == c_PC_MAX) begin
                  w_state_nx = c_ST_IDLE;
               end
            end
            if (!load_en) begin
               w_state_nx = c_ST_IDLE;
            end
         end

         c_ST_RUN: begin
            if (stall) begin
               w_pc_nx = r_pc;
            end else if (imem_data == HALT_INSTR) begin
               w_state_nx = c_ST_DONE;
               w_done_nx  = 1'b1;
            end else if (branch_taken) begin
               w_pc_nx = branch_target;
            end else if (r_pc == c_PC_MAX) begin
               // ran past the last memory location without a halt
               w_state_nx = c_ST_DONE;
               w_done_nx  = 1'b1;
            end else begin
               w_pc_nx = r_pc + c_PC_ONE;
            end
         end

         default: begin
            w_state_nx = c_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= c_ST_IDLE;
         r_pc      <= '0;
         r_wr_addr <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_pc      <= w_pc_nx;
         r_wr_addr <= w_wr_addr_nx;
         r_done    <= w_done_nx;
      end
   end

   sat_counter #(
      .WIDTH   (CNT_W)
   ) u_cycle_cnt (
      .clk     (clk),
      .rst     (reset),
      .i_clear (w_cnt_clear),
      .i_en    (w_in_run),
      .o_count (cycle_count)
   );

   assign load_ready   = w_in_load;
   assign imem_wr_en   = w_in_load & load_valid;
   assign imem_wr_addr = r_wr_addr;
   assign imem_wr_data = load_data;

   // pc is only meaningful on the read port once execution has begun
   assign imem_pc      = (w_in_run || (r_state == c_ST_DONE)) ? r_pc : '0;
   assign instr        = w_in_run ? imem_data : NOP_INSTR;
   assign instr_valid  = w_in_run & ~stall;
   assign done         = r_done;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed and randomized bench for fetch_ctrl against a
//               cycle-level behavioural model with its own memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

   localparam logic [8:0] NOP  = 9'b101100100;
   localparam logic [8:0] HALT = 9'b111111111;
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

   logic        clk = 1'b0;
   logic        reset, start, load_en, load_valid, stall, branch_taken;
   logic [8:0]  load_data;
   logic [7:0]  branch_target;
   logic        load_ready, imem_wr_en, instr_valid, done;
   logic [7:0]  imem_wr_addr, imem_pc;
   logic [8:0]  imem_wr_data, imem_data, instr;
   logic [15:0] cycle_count;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .load_en       (load_en),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_ready    (load_ready),
      .imem_wr_en    (imem_wr_en),
      .imem_wr_addr  (imem_wr_addr),
      .imem_wr_data  (imem_wr_data),
      .imem_pc       (imem_pc),
      .imem_data     (imem_data),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .done          (done),
      .cycle_count   (cycle_count)
   );

   // instruction memory written only by the DUT's write port
   logic [8:0] tbmem [256];
   assign imem_data = tbmem[imem_pc];
   int wr_pulses = 0;
   always @(posedge clk) begin
      if (imem_wr_en === 1'b1) begin
         tbmem[imem_wr_addr] <= imem_wr_data;
         wr_pulses <= wr_pulses + 1;
      end
   end

   // reference model
   logic [8:0] ref_mem [256];
   int m_mode, m_pc, m_wa, m_cnt;
   bit m_done;

   int tests = 0;
   int fails = 0;
   logic [8:0] prog [256];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      #1;
      if (!reset) begin
         chk("load_ready", {31'b0, load_ready}, {31'b0, m_mode == M_LOAD});
         chk("wr_en", {31'b0, imem_wr_en}, {31'b0, (m_mode == M_LOAD) && load_valid});
         if (m_mode == M_LOAD && load_valid) begin
            chk("wr_addr", {24'b0, imem_wr_addr}, m_wa);
            chk("wr_data", {23'b0, imem_wr_data}, {23'b0, load_data});
         end
         chk("instr", {23'b0, instr}, {23'b0, (m_mode == M_RUN) ? ref_mem[m_pc] : NOP});
         chk("instr_valid", {31'b0, instr_valid}, {31'b0, (m_mode == M_RUN) && !stall});
         if (m_mode == M_IDLE) chk("pc_idle", {24'b0, imem_pc}, 0);
         if (m_mode == M_RUN)  chk("pc_run", {24'b0, imem_pc}, m_pc);
         chk("done", {31'b0, done}, {31'b0, m_done});
         chk("cycle_count", {16'b0, cycle_count}, m_cnt);
      end
      if (reset) begin
         m_mode = M_IDLE; m_pc = 0; m_wa = 0; m_cnt = 0; m_done = 0;
      end else begin
         case (m_mode)
            M_IDLE, M_DONE: begin
               if (load_en) begin
                  m_mode = M_LOAD; m_wa = 0; m_done = 0;
               end else if (start) begin
                  m_mode = M_RUN; m_pc = 0; m_cnt = 0; m_done = 0;
               end
            end
            M_LOAD: begin
               if (load_valid) begin
                  ref_mem[m_wa] = load_data;
                  m_wa = (m_wa + 1) % 256;
                  if (m_wa == 0) m_mode = M_IDLE;
               end
               if (!load_en) m_mode = M_IDLE;
            end
            default: begin
               if (m_cnt < 65535) m_cnt++;
               if (!stall) begin
                  if (ref_mem[m_pc] == HALT) begin
                     m_mode = M_DONE; m_done = 1;
                  end else if (branch_taken) begin
                     m_pc = int'(branch_target);
                  end else if (m_pc == 255) begin
                     m_mode = M_DONE; m_done = 1;
                  end else begin
                     m_pc++;
                  end
               end
            end
         endcase
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_prog(input int n, input int gap_pct);
      load_en = 1; load_valid = 0;
      step();
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < gap_pct) begin
            load_valid = 0;
            step();
         end
         load_valid = 1; load_data = prog[i];
         step();
      end
      load_valid = 0;
      if (n == 256) step();
      load_en = 0;
      step();
   endtask

   task automatic run_prog(input int stall_pct, input int br_pct, input int maxcyc);
      int n = 0;
      start = 1;
      step();
      start = 0;
      while (m_mode == M_RUN && n < maxcyc) begin
         stall         = ($urandom_range(99) < stall_pct);
         branch_taken  = ($urandom_range(99) < br_pct);
         branch_target = 8'((m_pc + $urandom_range(1, 16) > 255) ? 255 : m_pc + $urandom_range(1, 16));
         step();
         n++;
      end
      stall = 0; branch_taken = 0;
      chk("run_done", {31'b0, done}, 1);
      step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         tbmem[i] = NOP; ref_mem[i] = NOP;
      end
      reset = 1; start = 0; load_en = 0; load_valid = 0; load_data = '0;
      stall = 0; branch_taken = 0; branch_target = '0;
      @(negedge clk);
      step(); step();
      reset = 0;
      step();
      chk("reset_instr", {23'b0, instr}, {23'b0, NOP});

      // three-word load with one idle gap
      wr_pulses = 0;
      load_en = 1; step();
      load_valid = 1; load_data = 9'h001; step();
      load_valid = 0; step();
      load_valid = 1; load_data = 9'h002; step();
      load_valid = 1; load_data = HALT;   step();
      load_valid = 0; load_en = 0; step();
      chk("load_pulses", wr_pulses, 3);

      // straight-line run
      run_prog(0, 0, 50);
      chk("straight_cnt", {16'b0, cycle_count}, 3);

      // branch then stall, then stalled halt
      for (int i = 0; i < 16; i++) prog[i] = 9'h003;
      prog[16] = 9'h004; prog[17] = HALT;
      load_prog(18, 0);
      start = 1; step(); start = 0;
      step();
      branch_taken = 1; branch_target = 8'h10; step();
      branch_taken = 0;
      chk("branch_pc", {24'b0, imem_pc}, 32'h10);
      stall = 1; step(); step();
      stall = 0; step();
      stall = 1; step(); step();
      stall = 0; step();
      step();
      chk("branch_cnt", {16'b0, cycle_count}, 8);

      // full-memory program without halt, wraps write address
      for (int i = 0; i < 256; i++) begin
         prog[i] = 9'($urandom_range(0, 510));
      end
      load_prog(256, 10);

      // reset in the middle of a run
      start = 1; step(); start = 0;
      for (int i = 0; i < 100 && m_pc != 'h17; i++) step();
      chk("pc_17", {24'b0, imem_pc}, 32'h17);
      reset = 1; step();
      reset = 0; step();
      chk("rst_pc", {24'b0, imem_pc}, 0);
      chk("rst_cnt", {16'b0, cycle_count}, 0);

      // fall off the end of memory
      run_prog(0, 0, 400);
      chk("end_cnt", {16'b0, cycle_count}, 256);

      // simultaneous start/load_en in DONE and IDLE, then rerun from DONE
      start = 1; load_en = 1; step();
      start = 0; load_en = 0; step();
      start = 1; load_en = 1; step();
      start = 0; load_en = 0; step();
      run_prog(0, 0, 400);
      run_prog(0, 0, 400);

      // randomized programs with stalls and forward branches
      for (int k = 0; k < 3; k++) begin
         int n = $urandom_range(1, 256);
         for (int i = 0; i < 256; i++) begin
            prog[i] = ($urandom_range(9) == 0) ? HALT : 9'($urandom_range(0, 511));
         end
         load_prog(n, 20);
         run_prog(25, 15, 3000);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_fetch_ctrl
`default_nettype wire
